// File: rtl/signed_compare_unit.sv
// signed_compare_unit
//   Registered integer compare unit for the RV64 integer datapath (branch
//   resolution, SLT/SLTU). One subtractor produces A - B. Equality is a
//   zero-detect on the difference. Signed less-than comes from the operand
//   and difference sign bits. Unsigned less-than comes from the subtractor
//   carry-out. Results appear one cycle after valid_i.
//
//   Optional feature macro: COMPARE_WORD_MODE_EN
//     When defined, the module gains a `word` input. With word=1 the compare
//     uses the 32-bit RV64 "W" view: sign at bit 31, 32-bit zero-detect and
//     carry, and diff is the sign-extended low word.
//
//   Ports:
//     clk      in   rising-edge clock
//     reset    in   synchronous, active-high reset
//     valid_i  in   operands valid this cycle
//     a, b     in   WIDTH-bit two's-complement operands
//     word     in   (COMPARE_WORD_MODE_EN only) select 32-bit word compare
//     valid_o  out  registered valid_i
//     diff     out  registered A - B, modulo 2^WIDTH
//     eq       out  A == B
//     lt       out  signed A < B
//     ltu      out  unsigned A < B
module signed_compare_unit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMPARE_WORD_MODE_EN
  input  logic             word,
`endif
  output logic             valid_o,
  output logic [WIDTH-1:0] diff,
  output logic             eq,
  output logic             lt,
  output logic             ltu
);

  logic [WIDTH-1:0] s_full;
  logic             c_full;
  logic [WIDTH-1:0] s_out;
  logic             a_sign;
  logic             b_sign;
  logic             s_sign;
  logic             eq_c;
  logic             lt_c;
  logic             ltu_c;

  // a + ~b + 1; the carry out of the top bit is 1 exactly when a >= b unsigned.
  assign {c_full, s_full} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

`ifdef COMPARE_WORD_MODE_EN
  logic [31:0] s_w;
  logic        c_w;

  assign {c_w, s_w} = {1'b0, a[31:0]} + {1'b0, ~b[31:0]} + 33'd1;
`endif

  always_comb begin
    a_sign = a[WIDTH-1];
    b_sign = b[WIDTH-1];
    s_sign = s_full[WIDTH-1];
    eq_c   = (s_full == '0);
    ltu_c  = ~c_full;
    s_out  = s_full;
`ifdef COMPARE_WORD_MODE_EN
    if (word) begin
      a_sign = a[31];
      b_sign = b[31];
      s_sign = s_w[31];
      eq_c   = (s_w == '0);
      ltu_c  = ~c_w;
      s_out  = {{(WIDTH-32){s_w[31]}}, s_w};
    end
`endif
    // Differing signs decide the result directly; only with equal signs is
    // the difference free of overflow, so only then is its sign trusted.
    lt_c = (a_sign != b_sign) ? a_sign : s_sign;
    if (eq_c) begin
      lt_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o <= 1'b0;
      diff    <= '0;
      eq      <= 1'b0;
      lt      <= 1'b0;
      ltu     <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        diff <= s_out;
        eq   <= eq_c;
        lt   <= lt_c;
        ltu  <= ltu_c;
      end
    end
  end

endmodule

// File: tb/tb_signed_compare_unit.sv
// tb_signed_compare_unit
//   Directed bench for signed_compare_unit: reset behaviour, small-signed
//   sweep, edge and overflow pairs, back-to-back throughput with hold, and
//   (when COMPARE_WORD_MODE_EN is defined) the word-mode view.
module tb_signed_compare_unit;

  logic        clk;
  logic        reset;
  logic        valid_i;
  logic [63:0] a;
  logic [63:0] b;
  logic        valid_o;
  logic [63:0] diff;
  logic        eq;
  logic        lt;
  logic        ltu;
`ifdef COMPARE_WORD_MODE_EN
  logic        word;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  signed_compare_unit #(.WIDTH(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .a       (a),
    .b       (b),
`ifdef COMPARE_WORD_MODE_EN
    .word    (word),
`endif
    .valid_o (valid_o),
    .diff    (diff),
    .eq      (eq),
    .lt      (lt),
    .ltu     (ltu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [63:0] e_diff,
                           input logic e_eq, input logic e_lt, input logic e_ltu);
    check({tag, "_valid"}, {63'd0, valid_o}, 64'd1);
    check({tag, "_diff"},  diff, e_diff);
    check({tag, "_eq"},    {63'd0, eq},  {63'd0, e_eq});
    check({tag, "_lt"},    {63'd0, lt},  {63'd0, e_lt});
    check({tag, "_ltu"},   {63'd0, ltu}, {63'd0, e_ltu});
  endtask

  initial begin
    longint ai;
    longint bi;
    n_checks = 0;
    n_errors = 0;
`ifdef COMPARE_WORD_MODE_EN
    word = 1'b0;
`endif

    // Reset held for two cycles with a live operand pair.
    reset   = 1'b1;
    valid_i = 1'b1;
    a       = 64'd5;
    b       = 64'd7;
    step();
    step();
    check("rst_valid", {63'd0, valid_o}, 64'd0);
    check("rst_diff",  diff, 64'd0);
    check("rst_eq",    {63'd0, eq},  64'd0);
    check("rst_lt",    {63'd0, lt},  64'd0);
    check("rst_ltu",   {63'd0, ltu}, 64'd0);

    // First result one cycle after reset drops: 5 - 7 = -2.
    reset = 1'b0;
    step();
    check_all("post_rst", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b1);

    // Edge pairs.
    a = 64'h8000_0000_0000_0000; b = 64'h7FFF_FFFF_FFFF_FFFF;
    step();
    check_all("minmax", 64'h0000_0000_0000_0001, 1'b0, 1'b1, 1'b0);

    a = 64'h0; b = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check_all("zero_m1", 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b1);

    // Overflowing subtraction: difference sign is 0 but a is negative.
    a = 64'h8000_0000_0000_0000; b = 64'h1;
    step();
    check_all("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);

    // Back-to-back pairs, then idle cycles that must hold the last result.
    a = 64'd3; b = 64'd3;
    step();
    check_all("b2b0", 64'd0, 1'b1, 1'b0, 1'b0);
    a = 64'd2; b = 64'd9;
    step();
    check_all("b2b1", 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b1, 1'b1);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1;
    step();
    check_all("b2b2", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0);
    valid_i = 1'b0;
    a = 64'd100; b = 64'd100;
    for (int k = 0; k < 2; k++) begin
      step();
      check("hold_valid", {63'd0, valid_o}, 64'd0);
      check("hold_diff",  diff, 64'hFFFF_FFFF_FFFF_FFFE);
      check("hold_eq",    {63'd0, eq},  64'd0);
      check("hold_lt",    {63'd0, lt},  64'd1);
      check("hold_ltu",   {63'd0, ltu}, 64'd0);
    end

`ifdef COMPARE_WORD_MODE_EN
    // 0x8000_0000 is negative in the word view, positive in the full view.
    valid_i = 1'b1;
    word = 1'b1;
    a = 64'h0000_0000_8000_0000; b = 64'h0;
    step();
    check_all("word1", 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1'b0);
    word = 1'b0;
    step();
    check_all("word0", 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b0);
`endif

    // Exhaustive small-signed sweep, one pair per cycle.
    valid_i = 1'b1;
    for (int i = -128; i <= 127; i++) begin
      for (int j = -128; j <= 127; j++) begin
        ai = i;
        bi = j;
        a  = ai;
        b  = bi;
        step();
        check("sweep_diff", diff, a - b);
        check("sweep_eq",   {63'd0, eq},  {63'd0, (i == j)});
        check("sweep_lt",   {63'd0, lt},  {63'd0, (i < j)});
        check("sweep_ltu",  {63'd0, ltu}, {63'd0, (a < b)});
      end
    end
    valid_i = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
